// File: rtl/punc_control.sv
// PUnC LC3 control unit: multi-cycle FSM sequencing fetch, decode and execute.
//
// Ports
//   clk, rst            rising-edge clock, asynchronous active-low reset
//   ir                  datapath instruction register
//   n, z, p             datapath condition flags
//   PC_*, IR_ld         PC mux selects and PC/IR strobes
//   addr_MEM_sel        memory address source (PC / ALU / store reg)
//   w_en_MEM            memory write enable
//   w_RF_sel            register-file write-back source (PC / mem / ALU)
//   r_addr_*_RF,
//   w_addr_RF, w_en_RF  register-file addresses and write enable
//   A_sel, B_sel        ALU operand selects
//   sext_sel, ALU_sel   sign-extension field and ALU operation
//   NZP_sel, N/Z/P_ld   flag source and flag load strobes
//   store_ld            load the indirect-address store register
//   halted              high in HALT
//   state_debug         current state encoding
//   instr_count         retired-instruction count (only with PUNC_INSTR_COUNT_EN)
//
// Optional feature: define PUNC_INSTR_COUNT_EN to add the instr_count output.
// Outputs are combinational from the state register and ir.

module punc_control #(
  // Documentation only; the datapath applies it when PC_clr is high.
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] ir,
  input  logic        n,
  input  logic        z,
  input  logic        p,
  output logic        PC_data_sel,
  output logic        PC_add_sel,
  output logic        PC_ld,
  output logic        PC_clr,
  output logic        PC_inc,
  output logic        IR_ld,
  output logic [1:0]  addr_MEM_sel,
  output logic        w_en_MEM,
  output logic [1:0]  w_RF_sel,
  output logic [2:0]  r_addr_0_RF,
  output logic [2:0]  r_addr_1_RF,
  output logic [2:0]  w_addr_RF,
  output logic        w_en_RF,
  output logic        A_sel,
  output logic        B_sel,
  output logic [1:0]  sext_sel,
  output logic [1:0]  ALU_sel,
  output logic        NZP_sel,
  output logic        N_ld,
  output logic        Z_ld,
  output logic        P_ld,
  output logic        store_ld,
  output logic        halted,
`ifdef PUNC_INSTR_COUNT_EN
  output logic [15:0] instr_count,
`endif
  output logic [2:0]  state_debug
);

  typedef enum logic [2:0] {
    StInit   = 3'd0,
    StFetch  = 3'd1,
    StDecode = 3'd2,
    StExec   = 3'd3,
    StExec2  = 3'd4,
    StHalt   = 3'd5
  } state_e;

  // Opcodes
  localparam logic [3:0] OpBr   = 4'b0000;
  localparam logic [3:0] OpAdd  = 4'b0001;
  localparam logic [3:0] OpLd   = 4'b0010;
  localparam logic [3:0] OpSt   = 4'b0011;
  localparam logic [3:0] OpJsr  = 4'b0100;
  localparam logic [3:0] OpAnd  = 4'b0101;
  localparam logic [3:0] OpLdr  = 4'b0110;
  localparam logic [3:0] OpStr  = 4'b0111;
  localparam logic [3:0] OpRti  = 4'b1000;
  localparam logic [3:0] OpNot  = 4'b1001;
  localparam logic [3:0] OpLdi  = 4'b1010;
  localparam logic [3:0] OpSti  = 4'b1011;
  localparam logic [3:0] OpJmp  = 4'b1100;
  localparam logic [3:0] OpRes  = 4'b1101;
  localparam logic [3:0] OpLea  = 4'b1110;
  localparam logic [3:0] OpTrap = 4'b1111;

  // Mux encodings
  localparam logic [1:0] AddrPc    = 2'b00;
  localparam logic [1:0] AddrAlu   = 2'b01;
  localparam logic [1:0] AddrStore = 2'b10;
  localparam logic [1:0] WbPc      = 2'b00;
  localparam logic [1:0] WbMem     = 2'b01;
  localparam logic [1:0] WbAlu     = 2'b10;
  localparam logic [1:0] SextImm5  = 2'b00;
  localparam logic [1:0] SextOff6  = 2'b01;
  localparam logic [1:0] SextOff9  = 2'b10;
  localparam logic [1:0] AluAdd    = 2'b00;
  localparam logic [1:0] AluAnd    = 2'b01;
  localparam logic [1:0] AluPassA  = 2'b10;
  localparam logic [1:0] AluNot    = 2'b11;

  state_e     state_q, state_d;
  logic [3:0] opcode;
  logic       br_taken;
  logic       flag_ld;

  assign opcode   = ir[15:12];
  assign br_taken = (ir[11] & n) | (ir[10] & z) | (ir[9] & p);

  // ir[4:3] carry no control information; RESET_PC is consumed by the datapath.
  logic unused_sig;
  assign unused_sig = ^{RESET_PC, ir[4:3]};

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StInit:   state_d = StFetch;
      StFetch:  state_d = StDecode;
      StDecode: state_d = (opcode == OpTrap) ? StHalt : StExec;
      StExec:   state_d = (opcode == OpLdi || opcode == OpSti) ? StExec2 : StFetch;
      StExec2:  state_d = StFetch;
      StHalt:   state_d = StHalt;
      default:  state_d = StInit;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StInit;
    end else begin
      state_q <= state_d;
    end
  end

  // Control outputs
  always_comb begin
    PC_data_sel  = 1'b0;
    PC_add_sel   = 1'b0;
    PC_ld        = 1'b0;
    PC_clr       = 1'b0;
    PC_inc       = 1'b0;
    IR_ld        = 1'b0;
    addr_MEM_sel = AddrPc;
    w_en_MEM     = 1'b0;
    w_RF_sel     = WbPc;
    r_addr_0_RF  = 3'd0;
    r_addr_1_RF  = 3'd0;
    w_addr_RF    = 3'd0;
    w_en_RF      = 1'b0;
    A_sel        = 1'b0;
    B_sel        = 1'b0;
    sext_sel     = SextImm5;
    ALU_sel      = AluAdd;
    NZP_sel      = 1'b0;
    flag_ld      = 1'b0;
    store_ld     = 1'b0;
    halted       = 1'b0;

    unique case (state_q)
      StInit: PC_clr = 1'b1;

      // Memory read is combinational: IR captures mem[PC] as PC increments.
      StFetch: begin
        addr_MEM_sel = AddrPc;
        IR_ld        = 1'b1;
        PC_inc       = 1'b1;
      end

      StDecode: ;

      StExec: begin
        unique case (opcode)
          OpAdd, OpAnd: begin
            r_addr_0_RF = ir[8:6];
            A_sel       = 1'b1;
            ALU_sel     = (opcode == OpAnd) ? AluAnd : AluAdd;
            if (ir[5]) begin
              B_sel    = 1'b1;
              sext_sel = SextImm5;
            end else begin
              r_addr_1_RF = ir[2:0];
            end
            w_RF_sel  = WbAlu;
            w_addr_RF = ir[11:9];
            w_en_RF   = 1'b1;
            flag_ld   = 1'b1;
          end

          OpNot: begin
            r_addr_0_RF = ir[8:6];
            A_sel       = 1'b1;
            ALU_sel     = AluNot;
            w_RF_sel    = WbAlu;
            w_addr_RF   = ir[11:9];
            w_en_RF     = 1'b1;
            flag_ld     = 1'b1;
          end

          OpBr: begin
            if (br_taken) begin
              PC_add_sel = 1'b1;
              PC_ld      = 1'b1;
            end
          end

          OpJmp: begin
            r_addr_0_RF = ir[8:6];
            A_sel       = 1'b1;
            ALU_sel     = AluPassA;
            PC_data_sel = 1'b1;
            PC_ld       = 1'b1;
          end

          // R7 takes the pre-jump PC at the same edge the PC loads, so JSRR R7
          // still reads the old R7 as its base.
          OpJsr: begin
            w_RF_sel  = WbPc;
            w_addr_RF = 3'd7;
            w_en_RF   = 1'b1;
            PC_ld     = 1'b1;
            if (!ir[11]) begin
              r_addr_0_RF = ir[8:6];
              A_sel       = 1'b1;
              ALU_sel     = AluPassA;
              PC_data_sel = 1'b1;
            end
          end

          OpLd, OpLea: begin
            B_sel     = 1'b1;
            sext_sel  = SextOff9;
            w_addr_RF = ir[11:9];
            w_en_RF   = 1'b1;
            flag_ld   = 1'b1;
            if (opcode == OpLd) begin
              addr_MEM_sel = AddrAlu;
              w_RF_sel     = WbMem;
              NZP_sel      = 1'b1;
            end else begin
              w_RF_sel = WbAlu;
            end
          end

          OpLdr: begin
            r_addr_0_RF  = ir[8:6];
            A_sel        = 1'b1;
            B_sel        = 1'b1;
            sext_sel     = SextOff6;
            addr_MEM_sel = AddrAlu;
            w_RF_sel     = WbMem;
            w_addr_RF    = ir[11:9];
            w_en_RF      = 1'b1;
            NZP_sel      = 1'b1;
            flag_ld      = 1'b1;
          end

          OpSt: begin
            B_sel        = 1'b1;
            sext_sel     = SextOff9;
            r_addr_1_RF  = ir[11:9];
            addr_MEM_sel = AddrAlu;
            w_en_MEM     = 1'b1;
          end

          OpStr: begin
            r_addr_0_RF  = ir[8:6];
            A_sel        = 1'b1;
            B_sel        = 1'b1;
            sext_sel     = SextOff6;
            r_addr_1_RF  = ir[11:9];
            addr_MEM_sel = AddrAlu;
            w_en_MEM     = 1'b1;
          end

          // First half of an indirect access: latch mem[PC+off9] as the address.
          OpLdi, OpSti: begin
            B_sel        = 1'b1;
            sext_sel     = SextOff9;
            addr_MEM_sel = AddrAlu;
            w_RF_sel     = WbMem;
            store_ld     = 1'b1;
          end

          OpRti, OpRes, OpTrap: ;

          default: ;
        endcase
      end

      StExec2: begin
        addr_MEM_sel = AddrStore;
        if (opcode == OpLdi) begin
          w_RF_sel  = WbMem;
          w_addr_RF = ir[11:9];
          w_en_RF   = 1'b1;
          NZP_sel   = 1'b1;
          flag_ld   = 1'b1;
        end else if (opcode == OpSti) begin
          r_addr_1_RF = ir[11:9];
          w_en_MEM    = 1'b1;
        end
      end

      StHalt: halted = 1'b1;

      default: ;
    endcase
  end

  assign N_ld        = flag_ld;
  assign Z_ld        = flag_ld;
  assign P_ld        = flag_ld;
  assign state_debug = state_q;

`ifdef PUNC_INSTR_COUNT_EN
  logic [15:0] count_q, count_d;
  logic        retire;

  // An instruction retires when control returns to FETCH from execution.
  always_comb begin
    retire  = (state_q == StExec || state_q == StExec2) && (state_d == StFetch);
    count_d = retire ? count_q + 16'd1 : count_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= 16'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign instr_count = count_q;
`endif

endmodule

// File: doc/punc_control.md
Name: punc_control

Overview:
- Control unit for the PUnC LC3 processor: a multi-cycle FSM that sequences fetch, decode and execute.
- Drives every control input of the PUnC datapath; consumes the instruction register and the N/Z/P condition flags the datapath returns.
- Sits beside the datapath in the PUnC top level and is the only source of datapath select, load and write-enable strobes.

Parameters:
- RESET_PC, 16'h0000: documentation only; PC_clr forces the datapath PC to this value on INIT.

Ports:
- clk  in  1  clock, rising-edge
- rst  in  1  asynchronous reset, active-low
- ir  in  16  datapath instruction register
- n, z, p  in  1 each  datapath condition flags
- PC_data_sel  out  1  0=adder, 1=ALU result (JMP/JSRR)
- PC_add_sel  out  1  0=PCoffset11, 1=PCoffset9
- PC_ld, PC_clr, PC_inc, IR_ld  out  1 each  PC/IR strobes
- addr_MEM_sel  out  2  00=PC, 01=ALU result, 10=store reg
- w_en_MEM  out  1  memory write enable
- w_RF_sel  out  2  00=PC, 01=mem data, 10=ALU result
- r_addr_0_RF, r_addr_1_RF, w_addr_RF  out  3 each  register-file addresses
- w_en_RF  out  1  register-file write enable
- A_sel  out  1  0=PC, 1=RF port 0
- B_sel  out  1  0=RF port 1, 1=sext
- sext_sel  out  2  00=imm5, 01=offset6, 10=offset9
- ALU_sel  out  2  00=ADD, 01=AND, 10=PASS_A, 11=NOT
- NZP_sel  out  1  0=ALU result, 1=mem data
- N_ld, Z_ld, P_ld  out  1 each  flag load strobes; always asserted together
- store_ld  out  1  load the indirect-address store register
- halted  out  1  high in HALT
- state_debug  out  3  current state encoding

Behaviour:
- States: INIT=0, FETCH=1, DECODE=2, EXEC=3, EXEC2=4, HALT=5.
- Single state register. Outputs are combinational from state and ir. The state register resets asynchronously to INIT.
- Any output not listed for a state or opcode is 0. While rst is low: PC_clr=1, all other outputs 0, halted=0, state_debug=0.
- INIT: PC_clr=1 -> FETCH.
- FETCH: addr_MEM_sel=00, IR_ld=1, PC_inc=1 -> DECODE. Memory read is combinational, so IR captures mem[PC] at the same edge that PC increments.
- DECODE: no strobes. ir[15:12]==4'b1111 -> HALT; otherwise -> EXEC.
- EXEC, by opcode:
  - ADD 0001 / AND 0101: r_addr_0=ir[8:6], A_sel=1, ALU_sel=00/01. If ir[5]=1: B_sel=1, sext_sel=00; else r_addr_1=ir[2:0]. w_RF_sel=10, w_addr=ir[11:9], w_en_RF=1, NZP_sel=0, flag loads=1.
  - NOT 1001: r_addr_0=ir[8:6], A_sel=1, ALU_sel=11, RF write as ADD, flag loads=1.
  - BR 0000: taken = (ir[11]&n)|(ir[10]&z)|(ir[9]&p). If taken: PC_add_sel=1, PC_data_sel=0, PC_ld=1. ir[11:9]=000 is never taken.
  - JMP 1100: r_addr_0=ir[8:6], A_sel=1, ALU_sel=10, PC_data_sel=1, PC_ld=1.
  - JSR/JSRR 0100: w_RF_sel=00, w_addr=7, w_en_RF=1, PC_ld=1. If ir[11]=1: PC_add_sel=0, PC_data_sel=0. Else: path as JMP. R7 receives the pre-jump PC. JSRR R7 uses the old R7 as the base.
  - LD 0010 / LEA 1110: A_sel=0, B_sel=1, sext_sel=10, ALU_sel=00. LD: addr_MEM_sel=01, w_RF_sel=01, NZP_sel=1. LEA: w_RF_sel=10, NZP_sel=0. Both: w_addr=ir[11:9], w_en_RF=1, flag loads=1.
  - LDR 0110: r_addr_0=ir[8:6], A_sel=1, B_sel=1, sext_sel=01, ALU_sel=00, addr_MEM_sel=01, w_RF_sel=01, w_addr=ir[11:9], w_en_RF=1, NZP_sel=1, flag loads=1.
  - ST 0011 / STR 0111: address formed as for LD / LDR. r_addr_1=ir[11:9], addr_MEM_sel=01, w_en_MEM=1.
  - LDI 1010 / STI 1011: address as LD, addr_MEM_sel=01, w_RF_sel=01, store_ld=1 -> EXEC2.
  - Reserved 1101 / RTI 1000: no-op.
- EXEC -> FETCH, except LDI/STI -> EXEC2.
- EXEC2: addr_MEM_sel=10.
  - LDI: w_RF_sel=01, w_addr=ir[11:9], w_en_RF=1, NZP_sel=1, flag loads=1.
  - STI: r_addr_1=ir[11:9], w_en_MEM=1.
  - -> FETCH.
- HALT: absorbing, halted=1, all strobes 0. Left only by reset.
- Reset asserted in any state, including EXEC2, returns to INIT asynchronously. No partial write may occur after rst falls.
- CPI: 3 cycles per instruction, 4 for LDI/STI, plus 1 INIT cycle after reset.

Optional Feature:
- Macro: PUNC_INSTR_COUNT_EN.
- With the macro defined: adds output instr_count (16 bits).
  - Increments on every transition into FETCH from EXEC or EXEC2.
  - Wraps from 16'hFFFF to 0.
  - Resets to 0.
  - Frozen in HALT.
- Without the macro: the port and the counter are absent.

Test Plan:
- Reset release -> INIT for 1 cycle with PC_clr=1, then FETCH with IR_ld=1, PC_inc=1, addr_MEM_sel=00.
- ir=16'h1261 (ADD R1,R1,#1) in EXEC -> B_sel=1, sext_sel=00, w_addr=1, w_en_RF=1, N/Z/P_ld=1, ALU_sel=00. The next state after EXEC is FETCH.
- ir=16'h0A02 (BRnp) with z=1 -> PC_ld=0. Same instruction with n=1 -> PC_ld=1, PC_add_sel=1.
- ir=16'hA402 (LDI R2) -> EXEC: store_ld=1, addr_MEM_sel=01. EXEC2: addr_MEM_sel=10, w_addr=2, w_en_RF=1, NZP_sel=1. Then FETCH.
- ir=16'h4080 (JSRR R2) -> w_addr=7, w_RF_sel=00, PC_data_sel=1, r_addr_0=2, PC_ld=1.
- ir=16'hF025 -> HALT with halted=1, held for 20 cycles. rst low -> INIT immediately. With PUNC_INSTR_COUNT_EN defined, instr_count resets to 0.
